// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared pipeline constants: memory FSM state encoding and
//               ALU operand forward-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Memory-stage handshake states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } mem_state_e;

  // ALU operand source select
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM alu_out
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Forwarding source select for one ALU operand. The youngest
//               producer (MEM) wins over WB; x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_M,
  input  logic       reg_write_M,
  input  logic [4:0] rd_W,
  input  logic       reg_write_W,
  output logic [1:0] sel
);

  // Pick the newest in-flight value that targets this source register
  always_comb begin
    sel = FWD_RF;
    if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage pipeline hazard unit: load-use stall, branch flush,
//               operand forwarding, data-memory wait/timeout FSM and
//               stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_write_E,
  input  logic             result_src_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_write_M,
  input  logic             mreq_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_write_W,
  input  logic             branch_taken_E,
  input  logic             mem_ack,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  mem_state_e        state;
  mem_state_e        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_busy;
  logic              load_use;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;

  fwd_sel u_fwd_a (
    .rs          (rs1_E),
    .rd_M        (rd_M),
    .reg_write_M (reg_write_M),
    .rd_W        (rd_W),
    .reg_write_W (reg_write_W),
    .sel         (sel_a)
  );

  fwd_sel u_fwd_b (
    .rs          (rs2_E),
    .rd_M        (rd_M),
    .reg_write_M (reg_write_M),
    .rd_W        (rd_W),
    .reg_write_W (reg_write_W),
    .sel         (sel_b)
  );

  assign mem_busy = (mreq_M & ~mem_ack) | (state == ERR);
  assign load_use = result_src_E & reg_write_E & (rd_E != 5'd0) &
                    ((rd_E == rs1_D) | (rd_E == rs2_D));
  assign bus_err  = (state == ERR);

  // Memory FSM next state; timeout fires on the MWAIT cycle that would
  // bring the wait count up to TIMEOUT
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mreq_M && !mem_ack) state_nxt = MWAIT;
      MWAIT: begin
        if (mem_ack)                     state_nxt = RUN;
        else if (wait_cnt >= WAIT_LAST)  state_nxt = ERR;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // State register and saturating wait counter (cleared on MWAIT entry)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && state_nxt == MWAIT) begin
        wait_cnt <= '0;
      end else if (state == MWAIT && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Stall/flush/forward decode; memory busy beats redirect beats load-use
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    fwd_a_E = sel_a;
    fwd_b_E = sel_b;
    if (rst) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_W = 1'b1;
      fwd_a_E = FWD_RF;
      fwd_b_E = FWD_RF;
    end else if (mem_busy) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (branch_taken_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  // Performance counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_F) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_E) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking scoreboard bench for pipe_hazard_ctrl
//               (TIMEOUT=4, CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       reg_write_E, result_src_E, reg_write_M, mreq_M, reg_write_W;
  logic       branch_taken_E, mem_ack;
  logic       stall_F, stall_D, stall_E, stall_M;
  logic       flush_D, flush_E, flush_W;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       bus_err;
  logic [7:0] stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [3:0] stl;   // {F,D,E,M}
    logic [2:0] fl;    // {D,E,W}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       berr;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] m_sc   = 8'd0;
  logic [7:0] m_fc   = 8'd0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .reg_write_E(reg_write_E), .result_src_E(result_src_E),
    .rd_M(rd_M), .reg_write_M(reg_write_M), .mreq_M(mreq_M),
    .rd_W(rd_W), .reg_write_W(reg_write_W),
    .branch_taken_E(branch_taken_E), .mem_ack(mem_ack),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .bus_err(bus_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, " stall_FDEM"}, {28'd0, stall_F, stall_D, stall_E, stall_M}, {28'd0, e.stl});
      check_val({e.tag, " flush_DEW"}, {29'd0, flush_D, flush_E, flush_W}, {29'd0, e.fl});
      check_val({e.tag, " fwd_a"}, {30'd0, fwd_a_E}, {30'd0, e.fa});
      check_val({e.tag, " fwd_b"}, {30'd0, fwd_b_E}, {30'd0, e.fb});
      check_val({e.tag, " bus_err"}, {31'd0, bus_err}, {31'd0, e.berr});
      check_val({e.tag, " stall_cnt"}, {24'd0, stall_cnt}, {24'd0, e.sc});
      check_val({e.tag, " flush_cnt"}, {24'd0, flush_cnt}, {24'd0, e.fc});
    end
  end

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    reg_write_E = 0; result_src_E = 0; reg_write_M = 0; mreq_M = 0;
    reg_write_W = 0; branch_taken_E = 0; mem_ack = 0;
  endtask

  task automatic load_use_on();
    rd_E = 5'd5; result_src_E = 1'b1; reg_write_E = 1'b1; rs1_D = 5'd5;
  endtask

  // Queue the expectation for the cycle just driven, then advance one cycle
  task automatic step(input string tag, input logic [3:0] stl, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic berr);
    exp_t e;
    if (rst) begin
      m_sc = 8'd0;
      m_fc = 8'd0;
    end
    e.tag = tag; e.stl = stl; e.fl = fl; e.fa = fa; e.fb = fb; e.berr = berr;
    e.sc = m_sc; e.fc = m_fc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst) begin
      m_sc = m_sc + 8'(stl[3]);
      m_fc = m_fc + 8'(fl[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Reset values, forwarding suppressed while in reset
    step("reset", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
    rs1_E = 5'd7; rd_M = 5'd7; reg_write_M = 1'b1;
    step("reset_fwd", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; idle();
    step("idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Load-use hazards
    load_use_on();
    step("lu_rs1", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
    idle();
    step("lu_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
    load_use_on(); rs1_D = 5'd0; rs2_D = 5'd5;
    step("lu_rs2", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
    result_src_E = 1'b0;
    step("no_load", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
    load_use_on(); rd_E = 5'd0; rs1_D = 5'd0; rs2_D = 5'd0;
    step("lu_x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Forwarding priority
    idle();
    rd_M = 5'd7; rd_W = 5'd7; reg_write_M = 1'b1; reg_write_W = 1'b1; rs2_E = 5'd7;
    step("fwd_mem", 4'b0000, 3'b000, 2'b00, 2'b10, 1'b0);
    rs1_E = 5'd7;
    step("fwd_mem_ab", 4'b0000, 3'b000, 2'b10, 2'b10, 1'b0);
    reg_write_M = 1'b0;
    step("fwd_wb", 4'b0000, 3'b000, 2'b01, 2'b01, 1'b0);
    rs1_E = 5'd3;
    step("fwd_mix", 4'b0000, 3'b000, 2'b00, 2'b01, 1'b0);
    rs2_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0; reg_write_M = 1'b1;
    step("fwd_x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Branch redirect overrides load-use
    idle(); load_use_on(); branch_taken_E = 1'b1;
    step("br_lu", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
    idle(); branch_taken_E = 1'b1;
    step("br", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);

    // Memory wait: 3 cycles without ack, then ack
    idle(); mreq_M = 1'b1;
    for (int i = 0; i < 3; i++) step("mwait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
    mem_ack = 1'b1;
    step("mwait_ack", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
    idle();
    step("mwait_run", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
    mreq_M = 1'b1; mem_ack = 1'b1;
    step("zero_wait", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
    idle();
    step("zero_wait_run", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Memory busy beats branch; redirect taken once memory completes
    mreq_M = 1'b1; branch_taken_E = 1'b1;
    step("busy_br", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
    mem_ack = 1'b1;
    step("busy_br_ack", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
    idle();
    step("busy_br_run", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Reset in the middle of MWAIT
    mreq_M = 1'b1;
    step("mid_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
    step("mid_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    step("mid_rst", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; idle();
    step("mid_rst_run", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Timeout: one RUN busy cycle plus four MWAIT cycles, then ERR
    mreq_M = 1'b1;
    for (int i = 0; i < 5; i++) step("tmo_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) step("tmo_err", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
    mreq_M = 1'b0;
    step("err_noreq", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
    mreq_M = 1'b1; mem_ack = 1'b1; branch_taken_E = 1'b1;
    step("err_sticky", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
    rst = 1'b1;
    step("err_rst", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; idle();
    step("err_cleared", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Counter wrap through 2^8
    load_use_on();
    for (int i = 0; i < 257; i++) step("wrap", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
    idle();
    step("wrap_end", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

    @(negedge clk);
    #1;
    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the max data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 SHALL provide ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rs1_D, rs2_D  in  5  source registers in ID.
- rs1_E, rs2_E, rd_E  in  5  registers held in ID/EX.
- reg_write_E, result_src_E  in  1  EX writes the register file; EX is a load.
- rd_M, reg_write_M, mreq_M  in  5/1/1  MEM destination, write enable, data-memory request.
- rd_W, reg_write_W  in  5/1  WB destination and write enable.
- branch_taken_E  in  1  EX redirects the PC (branch taken, jal or jalr).
- mem_ack  in  1  data memory completes the MEM-stage request this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- flush_D, flush_E, flush_W  out  1  clear IF/ID, ID/EX, MEM/WB to bubble.
- fwd_a_E, fwd_b_E  out  2  ALU operand select: 00 register file, 10 MEM alu_out, 01 WB result.
- bus_err  out  1  sticky memory timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-004 SHALL implement a memory FSM with states RUN, MWAIT, ERR; reset state is RUN.
REQ-005 SHALL move RUN->MWAIT when mreq_M=1 and mem_ack=0; it SHALL stay in RUN when mem_ack=1 in the same cycle (zero-wait access).
REQ-006 SHALL move MWAIT->RUN on the cycle mem_ack=1.
REQ-007 SHALL move MWAIT->ERR when the wait counter reaches TIMEOUT without mem_ack; ERR SHALL be left only by reset.
REQ-008 SHALL reset the wait counter to 0 on entry to MWAIT, increment it each MWAIT cycle, and saturate it (no wrap).
REQ-009 SHALL define mem_busy = (mreq_M & ~mem_ack) | (state==ERR).
- When mem_busy=1: stall_F, stall_D, stall_E, stall_M =1; flush_W=1; flush_D=0; flush_E=0.
REQ-010 SHALL treat load-use as result_src_E & reg_write_E & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D).
- When load-use=1 and mem_busy=0: stall_F=1, stall_D=1, flush_E=1.
REQ-011 SHALL, when branch_taken_E=1 and mem_busy=0: assert flush_D=1 and flush_E=1, and deassert stall_F and stall_D (the redirect overrides load-use).
REQ-012 SHALL give mem_busy priority over branch_taken_E; the redirect is deferred, not lost, because ID/EX is held.
REQ-013 SHALL set fwd_a_E=10 when reg_write_M & rd_M!=0 & rd_M==rs1_E.
- Else SHALL set fwd_a_E=01 when reg_write_W & rd_W!=0 & rd_W==rs1_E.
- Else fwd_a_E=00.
- fwd_b_E follows the same rules with rs2_E.
- MEM has priority over WB.
REQ-014 SHALL compute stall/flush/forward outputs combinationally from current inputs and state (0-cycle latency).
REQ-015 SHALL increment stall_cnt on each cycle with stall_F=1.
REQ-016 SHALL increment flush_cnt on each cycle with flush_E=1.
REQ-017 SHALL let both counters wrap modulo 2^CNT_W.
REQ-018 SHALL set bus_err=1 exactly while state==ERR.

Reset
REQ-019 SHALL, while rst=1: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, bus_err=0, all stall outputs 0, flush_D/E/W=1, fwd outputs 00.
REQ-020 SHALL abandon any in-progress MWAIT on a mid-operation reset, with no residual stall after rst falls.

Structure
REQ-021 SHALL place state encoding (RUN=2'd0, MWAIT=2'd1, ERR=2'd2) and forward-select constants (FWD_RF, FWD_MEM, FWD_WB) in the shared pipeline package.
REQ-022 SHALL factor the forwarding compare into one sub-module, fwd_sel, instantiated twice (operands a and b); the FSM and counters stay inline.

Verification
REQ-023 SHALL cover the following directed scenarios:
- Load-use: rd_E=5, result_src_E=1, reg_write_E=1, rs1_D=5 -> stall_F=stall_D=flush_E=1 for one cycle; stall_cnt +1.
- Forward priority: rd_M=rd_W=7, both write, rs2_E=7 -> fwd_b_E=10; clear reg_write_M -> 01; rs2_E=0 with rd=0 -> 00.
- Branch during load-use: branch_taken_E=1 with a load-use hazard -> flush_D=flush_E=1, stall_F=0.
- Memory wait: mreq_M=1, mem_ack low for 3 cycles then high -> stall_F..M and flush_W =1 for 3 cycles; RUN on cycle 4.
- Timeout: TIMEOUT=4, mem_ack never asserted -> ERR after 4 MWAIT cycles; bus_err=1 and stalls persist; rst clears both.
